// File: rtl/layer3_engine.sv
// Output-layer sequencer: walks the weight ROM one neuron per cycle, streams one dot-product
// score per neuron and reports the arg-max class when the last score has been produced.
module layer3_engine #(
    parameter int NUM_NEURONS = 10,
    parameter int NUM_INPUTS  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [NUM_INPUTS*8-1:0]               activations_flat,
    output logic [$clog2(NUM_NEURONS)-1:0]        neuron_index,
    input  logic [NUM_INPUTS*8-1:0]               neuron_weights_flat,
    output logic                                  busy,
    output logic                                  out_valid,
    output logic [$clog2(NUM_NEURONS)-1:0]        out_index,
    output logic [16+$clog2(NUM_INPUTS)-1:0]      out_value,
    output logic                                  done,
    output logic [$clog2(NUM_NEURONS)-1:0]        class_out
);

    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam int ACC_W = 16 + $clog2(NUM_INPUTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                   state_q;
    logic [NUM_INPUTS*8-1:0]  act_q;
    logic                     vld1_q;
    logic [IDX_W-1:0]         idx1_q;
    logic signed [ACC_W-1:0]  max_q;
    logic [IDX_W-1:0]         max_idx_q;
    logic                     first_q;

    logic signed [15:0]       prod [NUM_INPUTS];
    logic signed [ACC_W-1:0]  score;

    // ROM data arriving this cycle belongs to the neuron tracked in idx1_q.
    always_comb begin
        score = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            prod[i] = $signed({{8{act_q[i*8+7]}}, act_q[i*8 +: 8]})
                    * $signed({{8{neuron_weights_flat[i*8+7]}}, neuron_weights_flat[i*8 +: 8]});
            score = score + $signed({{(ACC_W-16){prod[i][15]}}, prod[i]});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            act_q        <= '0;
            vld1_q       <= 1'b0;
            idx1_q       <= '0;
            max_q        <= '0;
            max_idx_q    <= '0;
            first_q      <= 1'b0;
            neuron_index <= '0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_index    <= '0;
            out_value    <= '0;
            done         <= 1'b0;
            class_out    <= '0;
        end else begin
            done      <= 1'b0;
            out_valid <= vld1_q;
            if (vld1_q) begin
                out_index <= idx1_q;
                out_value <= score;
                // Strictly-greater keeps the lower index on ties.
                if (first_q || score > max_q) begin
                    max_q     <= score;
                    max_idx_q <= idx1_q;
                end
                first_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    vld1_q <= 1'b0;
                    if (start) begin
                        act_q        <= activations_flat;
                        neuron_index <= '0;
                        busy         <= 1'b1;
                        max_q        <= '0;
                        max_idx_q    <= '0;
                        first_q      <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    vld1_q <= 1'b1;
                    idx1_q <= neuron_index;
                    if (neuron_index == LAST_IDX) begin
                        state_q <= StDrain;
                    end else begin
                        neuron_index <= neuron_index + 1'b1;
                    end
                end
                StDrain: begin
                    vld1_q <= 1'b0;
                    if (out_valid && out_index == LAST_IDX) begin
                        done         <= 1'b1;
                        class_out    <= max_idx_q;
                        busy         <= 1'b0;
                        neuron_index <= '0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    vld1_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer3_engine.sv
// Directed bench for layer3_engine with a registered-read weight ROM model.
module tb_layer3_engine;

    localparam int NN = 10;
    localparam int NI = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [NI*8-1:0]     activations_flat;
    logic [3:0]          neuron_index;
    logic [NI*8-1:0]     neuron_weights_flat;
    logic                busy;
    logic                out_valid;
    logic [3:0]          out_index;
    logic [19:0]         out_value;
    logic                done;
    logic [3:0]          class_out;

    logic [NI*8-1:0]     rom [NN];

    int tests = 0;
    int fails = 0;
    int vcount = 0;
    int dcount = 0;
    int e [NN];

    layer3_engine #(.NUM_NEURONS(NN), .NUM_INPUTS(NI)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .activations_flat    (activations_flat),
        .neuron_index        (neuron_index),
        .neuron_weights_flat (neuron_weights_flat),
        .busy                (busy),
        .out_valid           (out_valid),
        .out_index           (out_index),
        .out_value           (out_value),
        .done                (done),
        .class_out           (class_out)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        neuron_weights_flat <= (int'(neuron_index) < NN) ? rom[neuron_index] : '0;
    end

    always @(posedge clk) begin
        if (out_valid === 1'b1) vcount = vcount + 1;
        if (done === 1'b1) dcount = dcount + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_oidx"}, out_index, 0);
        chk({tag, "_oval"}, $signed(out_value), 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_class"}, class_out, 0);
        chk({tag, "_nidx"}, neuron_index, 0);
    endtask

    task automatic fill_rom(input logic [7:0] w [NN]);
        for (int n = 0; n < NN; n++) rom[n] = {NI{w[n]}};
    endtask

    // Ends in the done cycle so a caller can chain the next start there.
    task automatic run(input string tag, input int exp_val [NN], input int exp_cls,
                       input bit poke);
        start = 1'b1;
        tick();
        start = 1'b0;
        vcount = 0;
        activations_flat = {NI{8'h5a}};
        chk({tag, "_busy_on"}, busy, 1);
        chk({tag, "_nidx0"}, neuron_index, 0);
        tick();
        chk({tag, "_nidx1"}, neuron_index, 1);
        chk({tag, "_novalid"}, out_valid, 0);
        for (int n = 0; n < NN; n++) begin
            start = poke && (n == 2);
            tick();
            start = 1'b0;
            chk($sformatf("%s_valid%0d", tag, n), out_valid, 1);
            chk($sformatf("%s_oidx%0d", tag, n), out_index, n);
            chk($sformatf("%s_val%0d", tag, n), $signed(out_value), exp_val[n]);
            chk($sformatf("%s_nodone%0d", tag, n), done, 0);
        end
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_class"}, class_out, exp_cls);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_valid_off"}, out_valid, 0);
        chk({tag, "_nidx_rst"}, neuron_index, 0);
        chk({tag, "_vcount"}, vcount, NN);
    endtask

    initial begin
        logic [7:0] w [NN];

        rst = 1'b1;
        start = 1'b0;
        activations_flat = '0;
        for (int n = 0; n < NN; n++) rom[n] = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (3) tick();
        chk_all_zero("idle");

        // Basic: acts 1, row n all n -> 16n, class 9
        for (int n = 0; n < NN; n++) begin
            w[n] = 8'(n);
            e[n] = 16 * n;
        end
        fill_rom(w);
        activations_flat = {NI{8'h01}};
        run("basic", e, 9, 1'b0);
        tick();
        chk("basic_done_pulse", done, 0);
        chk("basic_class_hold", class_out, 9);

        // start while busy is ignored
        activations_flat = {NI{8'h01}};
        run("poke", e, 9, 1'b1);
        repeat (4) tick();
        chk("poke_busy", busy, 0);
        chk("poke_vcount", vcount, NN);

        // start in the done cycle begins a second run
        activations_flat = {NI{8'h01}};
        run("chain_a", e, 9, 1'b0);
        activations_flat = {NI{8'h02}};
        for (int n = 0; n < NN; n++) e[n] = 32 * n;
        run("chain_b", e, 9, 1'b0);
        tick();

        // Extremes
        for (int n = 0; n < NN; n++) begin
            w[n] = 8'h80;
            e[n] = 262144;
        end
        fill_rom(w);
        activations_flat = {NI{8'h80}};
        run("ext_pos", e, 0, 1'b0);
        tick();
        for (int n = 0; n < NN; n++) begin
            w[n] = 8'h7f;
            e[n] = -260096;
        end
        fill_rom(w);
        activations_flat = {NI{8'h80}};
        run("ext_neg", e, 0, 1'b0);
        tick();

        // Ties
        for (int n = 0; n < NN; n++) begin
            w[n] = 8'h00;
            e[n] = 0;
        end
        fill_rom(w);
        activations_flat = {NI{8'h01}};
        run("tie_zero", e, 0, 1'b0);
        tick();
        for (int n = 0; n < NN; n++) begin
            w[n] = (n == 3 || n == 7) ? 8'd5 : 8'(n % 3);
            e[n] = 16 * int'(w[n]);
        end
        fill_rom(w);
        activations_flat = {NI{8'h01}};
        run("tie_37", e, 3, 1'b0);
        tick();

        // Reset mid-run
        for (int n = 0; n < NN; n++) begin
            w[n] = 8'(n);
            e[n] = 16 * n;
        end
        fill_rom(w);
        activations_flat = {NI{8'h01}};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("mid_valid", out_valid, 1);
        chk("mid_nidx", neuron_index, 5);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick();
        rst = 1'b0;
        dcount = 0;
        repeat (15) tick();
        chk("midrst_nodone", dcount, 0);
        chk_all_zero("midrst_idle");
        activations_flat = {NI{8'h01}};
        run("after_rst", e, 9, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer3_engine.md
# layer3_engine

Sequencer and dot-product engine for the final (output) layer of the network. It sits directly downstream of the layer-3 weight ROM.
- Drives the ROM's neuron index one neuron per cycle.
- Multiplies each returned 16-weight row against a latched vector of 16 signed 8-bit activations from layer 2.
- Streams one accumulated score per neuron.
- Reports the arg-max class once all NUM_NEURONS scores have been produced.

## Interface
Parameters:
- NUM_NEURONS, 10, number of output neurons (classes); must match the weight ROM.
- NUM_INPUTS, 16, activations per neuron; must match the weight ROM.
- ACC_W (localparam, not overridable), 16+$clog2(NUM_INPUTS) = 20, signed score width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock, shared with the weight ROM.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle request to run the layer; honoured only while idle.
- activations_flat  in  NUM_INPUTS*8  signed 8-bit activations; element i is at [i*8 +: 8]; sampled on the start edge.
- neuron_index  out  $clog2(NUM_NEURONS)  registered ROM address.
- neuron_weights_flat  in  NUM_INPUTS*8  ROM data; registered read, valid one cycle after the address is presented.
- busy  out  1  high while a run is in flight.
- out_valid  out  1  one-cycle strobe per neuron score.
- out_index  out  $clog2(NUM_NEURONS)  neuron number of the current score.
- out_value  out  ACC_W  signed score, sum over i of act[i]*w[i].
- done  out  1  one-cycle pulse after the last score.
- class_out  out  $clog2(NUM_NEURONS)  arg-max neuron; updated together with done and held until the next done.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE, start=1 on edge E0:
  - latch activations_flat;
  - neuron_index<=0; busy<=1;
  - clear the running max; go to ISSUE.
- ISSUE: neuron_index increments by 1 each cycle. After presenting NUM_NEURONS-1, hold that index (never wrap) and go to DRAIN.
- Issue-valid pipeline: a 2-stage valid/index shift register tracks ROM latency (1 cycle) plus the score register (1 cycle).
- Score path, all in one combinational stage, registered into out_value:
  - 16 signed 8x8 products, each sign-extended to ACC_W;
  - summed with no saturation; worst case ±262144 fits in 20 bits.
- Arg-max: updated on every score.
  - The first score of a run always loads the max.
  - Later scores replace it only if strictly greater, so ties keep the lower index.
- DRAIN:
  - when the last score has been registered, on the next edge pulse done, load class_out, set busy<=0, reset neuron_index<=0, and go to IDLE.
- start while busy is ignored. start sampled in the cycle done is high is accepted, because the FSM is already IDLE.
- activations_flat changes during a run have no effect.
- Reset (any time, including mid-run) clears to 0 immediately: busy, out_valid, out_index, out_value, done, class_out, neuron_index, running max, valid pipe; FSM goes to IDLE.
  - No done is produced for an aborted run.

## Timing
- Edge E0 samples start. neuron_index = n during the cycle after edge E(n).
- ROM data for neuron n is valid after E(n+1). The score for neuron n is registered at E(n+2): out_valid, out_index=n and out_value are high/valid in the cycle after E(n+2).
- Scores are emitted on consecutive cycles with no bubbles: NUM_NEURONS strobes.
- done and class_out are registered at E(NUM_NEURONS+2), i.e. E12 for the defaults. busy falls on the same edge.
- Total start-to-done latency is NUM_NEURONS+2 cycles. The earliest back-to-back start is at E(NUM_NEURONS+2).
- Reset values: all outputs 0.

## Test plan
- Reset check: assert rst with clk running → all outputs 0, no out_valid, no done until start.
- Basic run: activations all 1, ROM row n all 8'd(n), pulse start at E0:
  - out_value = 16n for n=0..9 on 10 consecutive cycles starting after E2;
  - done after E12; class_out=9.
- Extremes (no overflow):
  - activations all -128, weights all -128 → out_value 262144 (0x40000);
  - activations -128, weights 127 → -260096.
- Tie: all weights 0 → all scores 0, class_out=0. Rows 3 and 7 equal and maximal → class_out=3.
- Handshake:
  - start pulsed at E4 of a run → ignored, exactly 10 out_valid;
  - start pulsed in the done cycle → second run begins, done again 12 cycles later.
- Reset mid-run: assert rst after E5 → outputs 0 immediately, no done. A new start then completes normally with correct scores.
